// File: rtl/sp_render_if.sv
// Sprite renderer types and bus interface.
//
// sp_render_pkg : horizontal-state encoding and secondary OAM slot layout.
// sp_render_if  : groups every sp_render signal except clk/rst_n.
//   slave  modport : the renderer (timing/OAM/mask in, pixel out).
//   master modport : the driving side (PPU timing, secondary OAM, pixel mux).
// Optional macro SP_ZERO_HIT_EN adds sp0_in_range (in) and sp0_opaque (out).

package sp_render_pkg;

  typedef enum logic [1:0] {
    SL_PRE_CYC   = 2'd0,  // visible cycles 1..256
    SP_FETCH_CYC = 2'd1,  // sprite fetch cycles 257..320
    TL_PRE_CYC   = 2'd2,  // tile prefetch cycles 321..336
    HBLANK_CYC   = 2'd3   // 0 and 337..340
  } hs_state_t;

  typedef struct packed {
    logic       active;
    logic [7:0] y_pos;
    logic [7:0] tile_idx;
    logic [7:0] attribute;
    logic [7:0] x_pos;
    logic [7:0] bitmap_hi;
    logic [7:0] bitmap_lo;
  } second_oam_t;

endpackage

interface sp_render_if;
  import sp_render_pkg::*;

  logic        clk_en;
  logic [8:0]  row;
  logic [8:0]  col;
  hs_state_t   hs_state;
  logic        sp_en;
  logic        sp_left_en;
  logic [2:0]  sec_oam_rd_idx;
  second_oam_t sec_oam_rd_data;
  logic [3:0]  sp_pixel;
  logic        sp_priority;
  logic        sp_valid;
`ifdef SP_ZERO_HIT_EN
  logic        sp0_in_range;
  logic        sp0_opaque;
`endif

  modport slave (
`ifdef SP_ZERO_HIT_EN
    input  sp0_in_range,
    output sp0_opaque,
`endif
    input  clk_en,
    input  row,
    input  col,
    input  hs_state,
    input  sp_en,
    input  sp_left_en,
    output sec_oam_rd_idx,
    input  sec_oam_rd_data,
    output sp_pixel,
    output sp_priority,
    output sp_valid
  );

  modport master (
`ifdef SP_ZERO_HIT_EN
    output sp0_in_range,
    input  sp0_opaque,
`endif
    output clk_en,
    output row,
    output col,
    output hs_state,
    output sp_en,
    output sp_left_en,
    input  sec_oam_rd_idx,
    output sec_oam_rd_data,
    input  sp_pixel,
    input  sp_priority,
    input  sp_valid
  );

endinterface

// File: rtl/sp_render.sv
// Sprite pixel generator.
//
// Loads NUM_SPRITES slots from secondary OAM during cycles 321..328 of the
// prefetch window, then emits one prioritised sprite pixel per PPU clock
// during the next row's visible cycles.
//
// Ports:
//   clk   : master clock
//   rst_n : asynchronous active-low reset
//   bus   : sp_render_if.slave -- clk_en, row/col/hs_state timing, sp_en and
//           sp_left_en masks, secondary OAM read port, registered
//           sp_pixel/sp_priority/sp_valid outputs.
// Optional macro SP_ZERO_HIT_EN adds the sprite-0 opacity output sp0_opaque.

module sp_render
  import sp_render_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 8
) (
  input logic         clk,
  input logic         rst_n,
  sp_render_if.slave  bus
);

  logic [7:0] xcnt_q [NUM_SPRITES];
  logic [7:0] xcnt_d [NUM_SPRITES];
  logic [7:0] hi_q   [NUM_SPRITES];
  logic [7:0] hi_d   [NUM_SPRITES];
  logic [7:0] lo_q   [NUM_SPRITES];
  logic [7:0] lo_d   [NUM_SPRITES];
  logic [1:0] pal_q  [NUM_SPRITES];
  logic [1:0] pal_d  [NUM_SPRITES];
  logic       pri_q  [NUM_SPRITES];
  logic       pri_d  [NUM_SPRITES];
  logic       act_q  [NUM_SPRITES];
  logic       act_d  [NUM_SPRITES];

  logic [3:0] pix_q, pix_d;
  logic       spri_q, spri_d;
  logic       valid_q, valid_d;

  logic       load_phase, clear_row, render_phase;
  logic [2:0] rd_idx;
  logic [7:0] x;
  logic       left_mask;
  logic [1:0] pat [NUM_SPRITES];
  logic       win_found;
  logic [3:0] win_pix;
  logic       win_pri;
  second_oam_t ent;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always_comb begin
    ent          = bus.sec_oam_rd_data;
    load_phase   = (bus.hs_state == TL_PRE_CYC) && (bus.col >= 9'd321) && (bus.col <= 9'd328);
    clear_row    = (bus.col == 9'd320);
    render_phase = (bus.hs_state == SL_PRE_CYC) && (bus.col >= 9'd1) && (bus.col <= 9'd256) &&
                   (bus.row <= 9'd239);
    rd_idx       = load_phase ? 3'(bus.col - 9'd321) : 3'd0;
    x            = 8'(bus.col - 9'd1);
    left_mask    = !bus.sp_left_en && (x < 8'd8);
  end

  assign bus.sec_oam_rd_idx = rd_idx;

  // Slot pattern is only live once its x counter has expired.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      pat[i] = (act_q[i] && xcnt_q[i] == 8'd0) ? {hi_q[i][7], lo_q[i][7]} : 2'b00;
    end
  end

  // Lowest slot index with an opaque pattern wins.
  always_comb begin
    win_found = 1'b0;
    win_pix   = 4'd0;
    win_pri   = 1'b0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (!win_found && pat[i] != 2'b00) begin
        win_found = 1'b1;
        win_pix   = {pal_q[i], pat[i]};
        win_pri   = pri_q[i];
      end
    end
  end

  always_comb begin
    xcnt_d = xcnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    pal_d  = pal_q;
    pri_d  = pri_q;
    act_d  = act_q;
    if (bus.clk_en) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if (clear_row) begin
          xcnt_d[i] = 8'd0;
          hi_d[i]   = 8'd0;
          lo_d[i]   = 8'd0;
          pal_d[i]  = 2'd0;
          pri_d[i]  = 1'b0;
          act_d[i]  = 1'b0;
        end else if (load_phase) begin
          if (rd_idx == 3'(i)) begin
            xcnt_d[i] = ent.x_pos;
            pal_d[i]  = ent.attribute[1:0];
            pri_d[i]  = ent.attribute[5];
            act_d[i]  = ent.active;
            if (!ent.active) begin
              hi_d[i] = 8'd0;
              lo_d[i] = 8'd0;
            end else if (ent.attribute[6]) begin
              hi_d[i] = rev8(ent.bitmap_hi);
              lo_d[i] = rev8(ent.bitmap_lo);
            end else begin
              hi_d[i] = ent.bitmap_hi;
              lo_d[i] = ent.bitmap_lo;
            end
          end
        end else if (render_phase) begin
          if (xcnt_q[i] != 8'd0) begin
            xcnt_d[i] = xcnt_q[i] - 8'd1;
          end else begin
            hi_d[i] = {hi_q[i][6:0], 1'b0};
            lo_d[i] = {lo_q[i][6:0], 1'b0};
          end
        end
      end
    end
  end

  // Masking only gates the output; counters and shifters keep running.
  always_comb begin
    pix_d   = pix_q;
    spri_d  = spri_q;
    valid_d = valid_q;
    if (bus.clk_en) begin
      valid_d = render_phase;
      pix_d   = (render_phase && bus.sp_en && !left_mask) ? win_pix : 4'd0;
      spri_d  = render_phase ? win_pri : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        xcnt_q[i] <= 8'd0;
        hi_q[i]   <= 8'd0;
        lo_q[i]   <= 8'd0;
        pal_q[i]  <= 2'd0;
        pri_q[i]  <= 1'b0;
        act_q[i]  <= 1'b0;
      end
      pix_q   <= 4'd0;
      spri_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      xcnt_q  <= xcnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pal_q   <= pal_d;
      pri_q   <= pri_d;
      act_q   <= act_d;
      pix_q   <= pix_d;
      spri_q  <= spri_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sp_pixel    = pix_q;
  assign bus.sp_priority = spri_q;
  assign bus.sp_valid    = valid_q;

`ifdef SP_ZERO_HIT_EN
  logic sp0_q, sp0_d;
  logic hit_q, hit_d;

  always_comb begin
    sp0_d = sp0_q;
    hit_d = hit_q;
    if (bus.clk_en) begin
      if (clear_row) begin
        sp0_d = 1'b0;
      end else if (load_phase && rd_idx == 3'd0) begin
        sp0_d = bus.sp0_in_range;
      end
      // x == 255 never reports a hit.
      hit_d = render_phase && bus.sp_en && !left_mask && (x != 8'd255) && sp0_q &&
              (pat[0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp0_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      sp0_q <= sp0_d;
      hit_q <= hit_d;
    end
  end

  assign bus.sp0_opaque = hit_q;
`endif

  // Fields carried by the slot but consumed elsewhere in the PPU.
  logic unused_fields;
  assign unused_fields = ^{ent.y_pos, ent.tile_idx, ent.attribute[7], ent.attribute[4:2]};

endmodule

// File: tb/tb_sp_render.sv
// Scoreboard bench for sp_render: the stimulus pushes the hand-computed
// expected pixel for every visible step, a monitor pops on each clk_en edge.

module tb_sp_render;
  import sp_render_pkg::*;

  typedef struct {
    int         x;
    logic [3:0] pix;
    logic       pri;
    logic       hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sp_render_if bus ();

  sp_render dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  second_oam_t oam [8];
  always_comb bus.sec_oam_rd_data = oam[bus.sec_oam_rd_idx];

  exp_t       exp_q[$];
  logic [3:0] exp_pix [256];
  logic       exp_pri [256];
  logic       exp_hit [256];
  int         total = 0;
  int         bad = 0;
  logic [8:0] rst_col = 9'h1FF;
  hs_state_t  rst_hs = SL_PRE_CYC;

  task automatic chk(input string nm, input int x, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s x=%0d got=%0h want=%0h", nm, x, act, want);
    end
  endtask

  // Monitor: one output update per clk_en edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.clk_en && rst_n) begin
        #1;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("valid", e.x, bus.sp_valid, 1);
          chk("pixel", e.x, bus.sp_pixel, e.pix);
          chk("priority", e.x, bus.sp_priority, e.pri);
`ifdef SP_ZERO_HIT_EN
          chk("sp0_opaque", e.x, bus.sp0_opaque, e.hit);
`endif
        end else begin
          chk("idle_valid", -1, bus.sp_valid, 0);
          chk("idle_pixel", -1, bus.sp_pixel, 0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_pix"}, -1, bus.sp_pixel, 0);
    chk({nm, "_pri"}, -1, bus.sp_priority, 0);
    chk({nm, "_valid"}, -1, bus.sp_valid, 0);
`ifdef SP_ZERO_HIT_EN
    chk({nm, "_sp0"}, -1, bus.sp0_opaque, 0);
`endif
  endtask

  task automatic step(input logic [8:0] c, input hs_state_t h, input logic [8:0] r);
    exp_t e;
    @(negedge clk);
    bus.col      = c;
    bus.hs_state = h;
    bus.row      = r;
    if (h == SL_PRE_CYC && c >= 1 && c <= 256 && r <= 239) begin
      e.x   = int'(c) - 1;
      e.pix = exp_pix[c-1];
      e.pri = exp_pri[c-1];
      e.hit = exp_hit[c-1];
      exp_q.push_back(e);
    end
    bus.clk_en = 1'b1;
    @(negedge clk);
    bus.clk_en = 1'b0;
    if (c == rst_col && h == rst_hs) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic run_row(input logic [8:0] r);
    step(9'd320, SP_FETCH_CYC, r);
    for (int c = 321; c <= 336; c++) step(9'(c), TL_PRE_CYC, r);
    for (int c = 1; c <= 256; c++) step(9'(c), SL_PRE_CYC, r);
    step(9'd257, SP_FETCH_CYC, r);
  endtask

  // Inactive entries carry opaque bitmaps at x=0 so a leak would show.
  task automatic clear_all();
    for (int i = 0; i < 8; i++) begin
      oam[i].active    = 1'b0;
      oam[i].y_pos     = 8'h00;
      oam[i].tile_idx  = 8'h00;
      oam[i].attribute = 8'hFF;
      oam[i].x_pos     = 8'h00;
      oam[i].bitmap_hi = 8'hFF;
      oam[i].bitmap_lo = 8'hFF;
    end
    for (int i = 0; i < 256; i++) begin
      exp_pix[i] = 4'd0;
      exp_pri[i] = 1'b0;
      exp_hit[i] = 1'b0;
    end
    rst_col = 9'h1FF;
  endtask

  task automatic set_slot(input int i, input logic [7:0] xp, input logic [7:0] attr,
                          input logic [7:0] hi, input logic [7:0] lo);
    oam[i].active    = 1'b1;
    oam[i].x_pos     = xp;
    oam[i].attribute = attr;
    oam[i].bitmap_hi = hi;
    oam[i].bitmap_lo = lo;
  endtask

  initial begin
    bus.clk_en     = 1'b0;
    bus.row        = 9'd0;
    bus.col        = 9'd0;
    bus.hs_state   = HBLANK_CYC;
    bus.sp_en      = 1'b1;
    bus.sp_left_en = 1'b1;
`ifdef SP_ZERO_HIT_EN
    bus.sp0_in_range = 1'b0;
`endif
    clear_all();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single sprite, palette 2, pattern 3 at x=10 only.
    clear_all();
    set_slot(0, 8'd10, 8'h02, 8'h80, 8'h80);
    exp_pix[10] = 4'hB;
    run_row(9'd0);

    // Horizontal flip: lo=0x01 reversed appears at x_pos.
    clear_all();
    set_slot(0, 8'd20, 8'h40, 8'h00, 8'h01);
    exp_pix[20] = 4'h1;
    run_row(9'd1);

    // No flip: same byte appears 7 pixels later.
    clear_all();
    set_slot(0, 8'd20, 8'h00, 8'h00, 8'h01);
    exp_pix[27] = 4'h1;
    run_row(9'd2);

    // Overlap: slot 2 beats slot 5 at x=40, slot 5 alone at x=41.
    clear_all();
    set_slot(2, 8'd40, 8'h21, 8'h80, 8'h80);
    set_slot(5, 8'd40, 8'h03, 8'hC0, 8'hC0);
    exp_pix[40] = 4'h7;
    exp_pri[40] = 1'b1;
    exp_pix[41] = 4'hF;
    run_row(9'd3);

    // Right edge truncation, then an empty row shows nothing.
    clear_all();
    set_slot(0, 8'd252, 8'h00, 8'hFF, 8'h00);
    for (int i = 252; i <= 255; i++) exp_pix[i] = 4'h2;
    run_row(9'd4);
    clear_all();
    run_row(9'd5);

    // Left-8 masking: pixels 4..7 hidden, 8..11 shown.
    clear_all();
    set_slot(0, 8'd4, 8'h00, 8'hFF, 8'hFF);
    for (int i = 8; i <= 11; i++) exp_pix[i] = 4'h3;
    bus.sp_left_en = 1'b0;
    run_row(9'd6);
    bus.sp_left_en = 1'b1;

    // Sprites disabled.
    clear_all();
    set_slot(0, 8'd30, 8'h00, 8'hFF, 8'hFF);
    bus.sp_en = 1'b0;
    run_row(9'd7);
    bus.sp_en = 1'b1;

    // Row 240 is outside the visible area: no valid output at all.
    clear_all();
    set_slot(0, 8'd30, 8'h00, 8'hFF, 8'hFF);
    run_row(9'd240);

    // Reset during load at col 325: slot 0 lost, row stays empty.
    clear_all();
    set_slot(0, 8'd50, 8'h01, 8'hFF, 8'hFF);
    rst_col = 9'd325;
    rst_hs  = TL_PRE_CYC;
    run_row(9'd8);

    // Next full load restores operation.
    clear_all();
    set_slot(0, 8'd50, 8'h01, 8'hFF, 8'hFF);
    for (int i = 50; i <= 57; i++) exp_pix[i] = 4'h7;
    run_row(9'd9);

    // Reset mid-row at x=52: outputs drop at once and the slot is gone.
    clear_all();
    set_slot(0, 8'd50, 8'h01, 8'hFF, 8'hFF);
    for (int i = 50; i <= 52; i++) exp_pix[i] = 4'h7;
    rst_col = 9'd53;
    rst_hs  = SL_PRE_CYC;
    run_row(9'd10);

    // Sprite-0 opacity: reported at x=100, suppressed at x=255.
`ifdef SP_ZERO_HIT_EN
    bus.sp0_in_range = 1'b1;
`endif
    clear_all();
    set_slot(0, 8'd100, 8'h00, 8'h80, 8'h00);
    exp_pix[100] = 4'h2;
    exp_hit[100] = 1'b1;
    run_row(9'd11);
    clear_all();
    set_slot(0, 8'd255, 8'h00, 8'h80, 8'h00);
    exp_pix[255] = 4'h2;
    run_row(9'd12);

    repeat (4) @(negedge clk);
    chk("queue_drain", -1, exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_render.md
Name: sp_render

Overview:
- Sprite pixel generator, directly downstream of sprite evaluation.
- Loads up to NUM_SPRITES entries from secondary OAM during the tile-prefetch window. Each entry carries position, attribute and the two fetched bitmap bytes.
- During the next row's visible cycles, emits one prioritised sprite pixel per PPU clock to the pixel mux (background/sprite combine).

Parameters:
- NUM_SPRITES, 8, number of sprite slots; equals secondary OAM depth.

Ports:
- clk  input  1  master clock
- rst_n  input  1  asynchronous reset, active low
- clk_en  input  1  PPU clock enable (master/4); all state advances only when high
- row  input  9  current scanline, 0..261
- col  input  9  current cycle, 0..340
- hs_state  input  hs_state_t  horizontal state (SL_PRE_CYC = visible 1..256, TL_PRE_CYC = 321..336)
- sp_en  input  1  sprite rendering enable (PPUMASK bit 4)
- sp_left_en  input  1  show sprites in leftmost 8 pixels (PPUMASK bit 2)
- sec_oam_rd_idx  output  3  secondary OAM slot being read
- sec_oam_rd_data  input  second_oam_t  slot contents (active, y_pos, tile_idx, attribute, x_pos, bitmap_hi, bitmap_lo)
- sp_pixel  output  4  {palette[1:0], pattern[1:0]}; 0 = transparent
- sp_priority  output  1  attribute[5] of the winning sprite (1 = behind background)
- sp_valid  output  1  high on cycles where sp_pixel refers to a visible pixel

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), on clk.
- Reset clears all slots to inactive (x counter 0, shifters 0, attributes 0). sp_pixel, sp_priority and sp_valid reset to 0.
- Load phase: hs_state == TL_PRE_CYC and 321 <= col <= 328.
  - sec_oam_rd_idx = col - 321, truncated to 3 bits. Outside the load phase it holds 0.
  - Data is combinational; slot[idx] is captured on the same clk_en.
  - Captured per slot: xcnt <= x_pos, pal <= attribute[1:0], pri <= attribute[5], active.
  - Shifters: hi <= bitmap_hi, lo <= bitmap_lo. If attribute[6] (horizontal flip) is set, both bytes are bit-reversed on load.
  - An entry with active == 0 loads shifters as 0x00, so the slot is transparent.
- At col == 320, all slots are cleared before loading. An empty secondary OAM therefore never shows stale sprites.
- Render phase: hs_state == SL_PRE_CYC, 1 <= col <= 256, row <= 239. Pixel x = col - 1.
  - Per slot, every clk_en:
    - if xcnt != 0: xcnt <= xcnt - 1, no shift.
    - otherwise: the slot pixel is {hi[7], lo[7]}, then hi and lo shift left by 1 with 0 fill.
  - Each slot therefore yields exactly 8 pixels starting at x == x_pos. Shifting past 8 yields transparent.
  - x_pos 249..255: the sprite is truncated at x = 255 and does not wrap to the next row.
- Priority: the lowest-index slot with a nonzero 2-bit pattern wins. Winner output is {pal, pattern} and its pri.
- Masking, applied after priority:
  - sp_en == 0 forces sp_pixel = 0.
  - sp_left_en == 0 with x < 8 forces sp_pixel = 0.
  - Counters and shifters advance regardless of masking.
- Outputs are registered and updated on clk_en: one PPU-clock latency. The pixel for x = col - 1 appears after the clk_en at col.
- sp_valid is the registered render-phase qualifier. Outside the render phase, sp_pixel = 0 and sp_valid = 0.
- No state changes when clk_en == 0.
- Reset mid-load or mid-row: all slots go inactive immediately. The next full load phase restores operation.

Optional Feature:
- Macro SP_ZERO_HIT_EN.
- When defined, adds:
  - input sp0_in_range (1 bit): sprite 0 was copied into slot 0 by evaluation. It is captured in the slot-0 load at col 321.
  - output sp0_opaque (1 bit): registered. High when slot 0 produces a nonzero pattern at this pixel, after sp_left_en masking and with sp_en high. Also requires x != 255.
- sp0_opaque resets to 0. The pixel mux ANDs it with background opacity for the sprite-0-hit flag.
- When not defined, neither port exists and no logic is generated.

Test Plan:
- Slot0 x_pos=10, bitmap_hi=0x80, bitmap_lo=0x80, attribute=0x02, others inactive -> sp_pixel=0xB at x=10 only. sp_pixel=0 at x=9 and x=11; sp_valid high for x 0..255.
- Slot0 bitmap_lo=0x01 with attribute[6]=1, x_pos=20 -> pattern 1 at x=20. Without flip -> pattern 1 at x=27.
- Slots 2 and 5 overlapping at x=40, both opaque, slot5 attribute=0x03, slot2 attribute=0x21 -> sp_pixel={01,pattern of slot2}, sp_priority=1. Slot2 transparent at x=41 -> slot5 wins with palette 3.
- x_pos=252, bitmap 0xFF/0x00 -> pattern 2 at x=252..255, nothing at x=0 of the next row. x_pos=4 with sp_left_en=0 -> 0 at x=4..7, pixels at x=8..11.
- All slots inactive, then rst_n pulsed low at col 325 -> all outputs 0 immediately. Next row's load then renders normally.
- SP_ZERO_HIT_EN defined, sp0_in_range=1, slot0 opaque at x=255 -> sp0_opaque=0. Same sprite at x=100 -> sp0_opaque=1 for one PPU clock.
